// File: rtl/mc_pkg.sv
// Shared constants and types for the multicycle controller, its decoder and
// the datapath blocks (extender, ALU) that consume the same encodings.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_NANDI = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_B     = 6'b111111;
  localparam logic [5:0] OP_BEQ   = 6'b000000;
  localparam logic [5:0] OP_BNE   = 6'b000001;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_NOT   = 4'b0100;
  localparam logic [3:0] ALU_NAND  = 4'b0101;
  localparam logic [3:0] ALU_SHL16 = 4'b1000;

  localparam logic [1:0] IMM_SEXT   = 2'b00;
  localparam logic [1:0] IMM_ZFILL  = 2'b01;
  localparam logic [1:0] IMM_SEXT2  = 2'b10;
  localparam logic [1:0] IMM_UNUSED = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU, CL_LOAD, CL_STORE, CL_B, CL_BEQ, CL_BNE, CL_ILL
  } iclass_t;

  typedef struct packed {
    iclass_t    iclass;
    logic       byte_acc;
    logic       asel;
    logic       bsel;
    logic [3:0] alu_op;
    logic [1:0] imm_mode;
  } dec_t;

  // Once trapped, the original cause must survive any later fault.
  function automatic logic [1:0] keep_first_cause(input logic       trapped,
                                                  input logic [1:0] cur_cause,
                                                  input logic [1:0] new_cause);
    logic [1:0] res;
    if (trapped) begin
      res = cur_cause;
    end else begin
      res = new_cause;
    end
    return res;
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode decoder: instruction class, ALU operation, operand
// selects and extender mode for the EXEC cycle.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [3:0] func,
  output dec_t       dec,
  output logic       illegal
);

  // Opcode map; anything not listed falls to the illegal class.
  always_comb begin
    dec.iclass   = CL_ILL;
    dec.byte_acc = 1'b0;
    dec.asel     = 1'b0;
    dec.bsel     = 1'b0;
    dec.alu_op   = ALU_ADD;
    dec.imm_mode = IMM_SEXT;
    case (opcode)
      OP_RTYPE: begin
        dec.iclass = CL_ALU;
        dec.alu_op = func;
      end
      OP_LI: begin
        dec.iclass = CL_ALU;
        dec.asel   = 1'b1;
        dec.bsel   = 1'b1;
      end
      OP_LUI: begin
        dec.iclass   = CL_ALU;
        dec.asel     = 1'b1;
        dec.bsel     = 1'b1;
        dec.alu_op   = ALU_SHL16;
        dec.imm_mode = IMM_ZFILL;
      end
      OP_ADDI: begin
        dec.iclass = CL_ALU;
        dec.bsel   = 1'b1;
      end
      OP_NANDI: begin
        dec.iclass   = CL_ALU;
        dec.bsel     = 1'b1;
        dec.alu_op   = ALU_NAND;
        dec.imm_mode = IMM_ZFILL;
      end
      OP_ORI: begin
        dec.iclass   = CL_ALU;
        dec.bsel     = 1'b1;
        dec.alu_op   = ALU_OR;
        dec.imm_mode = IMM_ZFILL;
      end
      OP_B: begin
        dec.iclass   = CL_B;
        dec.imm_mode = IMM_SEXT2;
      end
      OP_BEQ: begin
        dec.iclass   = CL_BEQ;
        dec.alu_op   = ALU_SUB;
        dec.imm_mode = IMM_SEXT2;
      end
      OP_BNE: begin
        dec.iclass   = CL_BNE;
        dec.alu_op   = ALU_SUB;
        dec.imm_mode = IMM_SEXT2;
      end
      OP_LB: begin
        dec.iclass   = CL_LOAD;
        dec.bsel     = 1'b1;
        dec.byte_acc = 1'b1;
      end
      OP_LW: begin
        dec.iclass = CL_LOAD;
        dec.bsel   = 1'b1;
      end
      OP_SB: begin
        dec.iclass   = CL_STORE;
        dec.bsel     = 1'b1;
        dec.byte_acc = 1'b1;
      end
      OP_SW: begin
        dec.iclass = CL_STORE;
        dec.bsel   = 1'b1;
      end
      default: begin
        dec.iclass = CL_ILL;
      end
    endcase
    illegal = (dec.iclass == CL_ILL);
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle control FSM: sequences the shared memory port, register file,
// ALU and extender, with sticky traps for illegal opcodes and memory timeouts.
module mc_control
  import mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [5:0] OpCode,
  input  logic [3:0] Func,
  input  logic       ALU_Zero,
  input  logic       Mem_Ack,
  output logic       Mem_Req,
  output logic       Mem_AddrSel,
  output logic       Mem_We,
  output logic       Mem_Byte,
  output logic       IR_LdEn,
  output logic       MDR_LdEn,
  output logic       RF_WrEn,
  output logic       RF_WrDataSel,
  output logic       ALU_Asel,
  output logic       ALU_Bsel,
  output logic [3:0] ALU_Op,
  output logic [1:0] Imm_Mode,
  output logic       PC_LdEn,
  output logic       PC_Sel,
  output logic       Trap,
  output logic [1:0] Trap_Cause
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};

  state_t          state_r;
  logic [TO_W-1:0] to_cnt_r;
  logic            trap_r;
  logic [1:0]      cause_r;

  dec_t dec_s;
  logic illegal_s;
  logic is_load_s;
  logic is_store_s;
  logic to_hit_s;

  mc_decode u_decode (
    .opcode  (OpCode),
    .func    (Func),
    .dec     (dec_s),
    .illegal (illegal_s)
  );

  assign is_load_s  = (dec_s.iclass == CL_LOAD);
  assign is_store_s = (dec_s.iclass == CL_STORE);
  // Only meaningful in FETCH/MEM; an ack in the same cycle takes priority.
  assign to_hit_s   = (to_cnt_r == TO_LAST);

  assign Trap       = trap_r;
  assign Trap_Cause = cause_r;

  // State sequencing, memory timeout counter and sticky trap registers.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r  <= S_RST;
      to_cnt_r <= '0;
      trap_r   <= 1'b0;
      cause_r  <= CAUSE_NONE;
    end else begin
      case (state_r)
        S_RST: begin
          state_r  <= S_FETCH;
          to_cnt_r <= '0;
        end
        S_FETCH: begin
          if (Mem_Ack) begin
            state_r <= S_DECODE;
          end else if (to_hit_s) begin
            state_r <= S_TRAP;
            trap_r  <= 1'b1;
            cause_r <= keep_first_cause(trap_r, cause_r, CAUSE_TIMEOUT);
          end else begin
            to_cnt_r <= to_cnt_r + TO_ONE;
          end
        end
        S_DECODE: begin
          if (illegal_s) begin
            state_r <= S_TRAP;
            trap_r  <= 1'b1;
            cause_r <= keep_first_cause(trap_r, cause_r, CAUSE_ILLEGAL);
          end else begin
            state_r <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (dec_s.iclass)
            CL_LOAD, CL_STORE: begin
              state_r  <= S_MEM;
              to_cnt_r <= '0;
            end
            CL_ALU: begin
              state_r <= S_WB;
            end
            CL_B, CL_BEQ, CL_BNE: begin
              state_r  <= S_FETCH;
              to_cnt_r <= '0;
            end
            default: begin
              state_r <= S_TRAP;
              trap_r  <= 1'b1;
              cause_r <= keep_first_cause(trap_r, cause_r, CAUSE_ILLEGAL);
            end
          endcase
        end
        S_MEM: begin
          if (Mem_Ack) begin
            if (is_load_s) begin
              state_r <= S_WB;
            end else begin
              state_r  <= S_FETCH;
              to_cnt_r <= '0;
            end
          end else if (to_hit_s) begin
            state_r <= S_TRAP;
            trap_r  <= 1'b1;
            cause_r <= keep_first_cause(trap_r, cause_r, CAUSE_TIMEOUT);
          end else begin
            to_cnt_r <= to_cnt_r + TO_ONE;
          end
        end
        S_WB: begin
          state_r  <= S_FETCH;
          to_cnt_r <= '0;
        end
        S_TRAP: begin
          state_r <= S_TRAP;
        end
        default: begin
          state_r <= S_RST;
        end
      endcase
    end
  end

  // Datapath controls decoded from the current state and instruction class.
  always_comb begin
    Mem_Req      = 1'b0;
    Mem_AddrSel  = 1'b0;
    Mem_We       = 1'b0;
    Mem_Byte     = 1'b0;
    IR_LdEn      = 1'b0;
    MDR_LdEn     = 1'b0;
    RF_WrEn      = 1'b0;
    RF_WrDataSel = 1'b0;
    ALU_Asel     = 1'b0;
    ALU_Bsel     = 1'b0;
    ALU_Op       = ALU_ADD;
    Imm_Mode     = IMM_SEXT;
    PC_LdEn      = 1'b0;
    PC_Sel       = 1'b0;
    case (state_r)
      S_FETCH: begin
        Mem_Req = 1'b1;
        IR_LdEn = Mem_Ack;
      end
      S_EXEC: begin
        ALU_Asel = dec_s.asel;
        ALU_Bsel = dec_s.bsel;
        ALU_Op   = dec_s.alu_op;
        Imm_Mode = dec_s.imm_mode;
        case (dec_s.iclass)
          CL_B: begin
            PC_LdEn = 1'b1;
            PC_Sel  = 1'b1;
          end
          CL_BEQ: begin
            PC_LdEn = 1'b1;
            PC_Sel  = ALU_Zero;
          end
          CL_BNE: begin
            PC_LdEn = 1'b1;
            PC_Sel  = ~ALU_Zero;
          end
          default: begin
            PC_LdEn = 1'b0;
            PC_Sel  = 1'b0;
          end
        endcase
      end
      S_MEM: begin
        Mem_Req     = 1'b1;
        Mem_AddrSel = 1'b1;
        Mem_We      = is_store_s;
        Mem_Byte    = dec_s.byte_acc;
        if (Mem_Ack) begin
          MDR_LdEn = is_load_s;
          PC_LdEn  = is_store_s;
        end else begin
          MDR_LdEn = 1'b0;
          PC_LdEn  = 1'b0;
        end
      end
      S_WB: begin
        RF_WrEn      = 1'b1;
        RF_WrDataSel = is_load_s;
        PC_LdEn      = 1'b1;
      end
      default: begin
        Mem_Req = 1'b0;
      end
    endcase
  end

endmodule
